// File: rtl/cdd_pkg.sv
// Shared definitions for the sequential carry-disregard divider slice.
// Provides the default operand widths, the divider FSM state type and the
// iteration counter width used by cdd_seq_divider.
package cdd_pkg;

  localparam int A_W_DEF = 8;                  // quotient width
  localparam int B_W_DEF = 4;                  // divisor / remainder width
  localparam int R_W_DEF = A_W_DEF + B_W_DEF;  // dividend width
  localparam int CNT_W   = $clog2(A_W_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cdd_seq_divider_if.sv
// Operand/result handshake bundle for cdd_seq_divider.
//   master : producer/consumer side (drives in_valid, dividend, divisor, out_ready)
//   slave  : divider side (drives in_ready, out_valid, quotient, remainder, ovf[, div0])
// Optional macro CDD_DIV0_FLAG_EN adds the div0 result flag.
interface cdd_seq_divider_if
  import cdd_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int B_W = B_W_DEF
);
  localparam int R_W = A_W + B_W;

  logic           in_valid;
  logic           in_ready;
  logic [R_W-1:0] dividend;
  logic [B_W-1:0] divisor;
  logic           out_valid;
  logic           out_ready;
  logic [A_W-1:0] quotient;
  logic [B_W-1:0] remainder;
  logic           ovf;
`ifdef CDD_DIV0_FLAG_EN
  logic           div0;
`endif

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, ovf
`ifdef CDD_DIV0_FLAG_EN
    , input div0
`endif
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, ovf
`ifdef CDD_DIV0_FLAG_EN
    , output div0
`endif
  );

endinterface

// File: rtl/cdd_step.sv
// One restoring-division step (purely combinational).
//   rem      in  B_W  current partial remainder (always < divisor)
//   bit_in   in  1    next dividend bit, MSB first
//   divisor  in  B_W  divisor
//   rem_next out B_W  partial remainder after the step
//   q_bit    out 1    quotient bit produced by the step
module cdd_step #(
  parameter int B_W = 4
) (
  input  logic [B_W-1:0] rem,
  input  logic           bit_in,
  input  logic [B_W-1:0] divisor,
  output logic [B_W-1:0] rem_next,
  output logic           q_bit
);

  logic [B_W:0]   shifted;
  logic [B_W-1:0] trial_lo;

  assign shifted = {rem, bit_in};
  // The trial result is always < divisor when kept, so its carry bit is
  // never needed: the low B_W bits of the wide subtraction are enough.
  assign trial_lo = shifted[B_W-1:0] - divisor;
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign rem_next = q_bit ? trial_lo : shifted[B_W-1:0];

endmodule

// File: rtl/cdd_seq_divider.sv
// Sequential restoring divider, inverse of the 8x4 carry-disregard multiplier.
// Divides an R_W-bit dividend by a B_W-bit divisor, one quotient bit per
// clock, producing an A_W-bit quotient and B_W-bit remainder.
//   clk   in  clock, all state on rising edge
//   rst   in  synchronous active-high reset
//   bus   slave modport of cdd_seq_divider_if (operand and result handshakes)
// Quotients that do not fit in A_W bits (including divide-by-zero) finish
// after one clock with quotient all ones, remainder 0, ovf 1.
// Optional macro CDD_DIV0_FLAG_EN adds the registered div0 flag.
module cdd_seq_divider
  import cdd_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int B_W = B_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  cdd_seq_divider_if.slave   bus
);

  localparam int R_W = A_W + B_W;
  localparam int CW  = $clog2(A_W + 1);

  state_t         state;
  logic [B_W-1:0] rem;       // partial remainder
  logic [A_W-1:0] q_sr;      // dividend bits shift out of the top, quotient bits in at the bottom
  logic [B_W-1:0] dvs;       // captured divisor
  logic [CW-1:0]  cnt;       // steps completed

  logic           in_ready_r;
  logic           out_valid_r;
  logic [A_W-1:0] quot_r;
  logic [B_W-1:0] rem_r;
  logic           ovf_r;
`ifdef CDD_DIV0_FLAG_EN
  logic           div0_r;
`endif

  logic [B_W-1:0] step_rem;
  logic           step_q;

  cdd_step #(.B_W(B_W)) u_step (
    .rem      (rem),
    .bit_in   (q_sr[A_W-1]),
    .divisor  (dvs),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // NOTE: reset is sampled on the clock edge (synchronous), so rst sits inside the edge-triggered branch, not the sensitivity list.
  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      q_sr        <= '0;
      dvs         <= '0;
      cnt         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      quot_r      <= '0;
      rem_r       <= '0;
      ovf_r       <= 1'b0;
`ifdef CDD_DIV0_FLAG_EN
      div0_r      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            in_ready_r <= 1'b0;
            dvs        <= bus.divisor;
            // Upper dividend bits >= divisor means the quotient needs more
            // than A_W bits; divisor 0 always lands here.
            if (bus.dividend[R_W-1:A_W] >= bus.divisor) begin
              state       <= DONE;
              out_valid_r <= 1'b1;
              quot_r      <= '1;
              rem_r       <= '0;
              ovf_r       <= 1'b1;
`ifdef CDD_DIV0_FLAG_EN
              div0_r      <= (bus.divisor == '0);
`endif
            end else begin
              state <= BUSY;
              rem   <= bus.dividend[R_W-1:A_W];
              q_sr  <= bus.dividend[A_W-1:0];
              cnt   <= '0;
            end
          end
        end
        BUSY: begin
          rem  <= step_rem;
          q_sr <= {q_sr[A_W-2:0], step_q};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(A_W - 1)) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            quot_r      <= {q_sr[A_W-2:0], step_q};
            rem_r       <= step_rem;
            ovf_r       <= 1'b0;
`ifdef CDD_DIV0_FLAG_EN
            div0_r      <= 1'b0;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.quotient  = quot_r;
  assign bus.remainder = rem_r;
  assign bus.ovf       = ovf_r;
`ifdef CDD_DIV0_FLAG_EN
  assign bus.div0      = div0_r;
`endif

endmodule

// File: tb/tb_cdd_seq_divider.sv
// Self-checking bench for cdd_seq_divider: directed cases plus randomized
// operands, compared against a plain-arithmetic division model and an
// in-order scoreboard of every accepted operand pair.
module tb_cdd_seq_divider;
  import cdd_pkg::*;

  typedef struct {
    int q;
    int r;
    bit o;
    bit z;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdd_seq_divider_if bus ();

  cdd_seq_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int n_out = 0;
  res_t exp_q[$];
  res_t out_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact integer division; anything that does not fit in the
  // quotient width (or divides by zero) reports all ones / 0 / ovf.
  function automatic res_t model(input int dvd, input int dvs);
    res_t r;
    if (dvs == 0 || (dvd / dvs) > 255) begin
      r.q = 255; r.r = 0; r.o = 1'b1; r.z = (dvs == 0);
    end else begin
      r.q = dvd / dvs; r.r = dvd % dvs; r.o = 1'b0; r.z = 1'b0;
    end
    return r;
  endfunction

  // Scoreboard: expectations queued on operand accept, compared in order on
  // result handshake; a reset discards everything in flight.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(int'(bus.dividend), int'(bus.divisor)));
        n_acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        res_t e, o;
        n_out++;
        o.q = int'(bus.quotient); o.r = int'(bus.remainder); o.o = bus.ovf; o.z = 1'b0;
        out_log.push_back(o);
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_quotient", bus.quotient, e.q);
          check("sb_remainder", bus.remainder, e.r);
          check("sb_ovf", bus.ovf, e.o);
`ifdef CDD_DIV0_FLAG_EN
          check("sb_div0", bus.div0, e.z);
`endif
        end
      end
    end
  end

  task automatic start_op(input int dvd, input int dvs);
    int g = 0;
    while (!bus.in_ready && g < 100) begin
      @(posedge clk); #1; g++;
    end
    if (!bus.in_ready) check("accept_wait_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.dividend = 12'(dvd);
    bus.divisor  = 4'(dvs);
    @(posedge clk); #1;          // accepting edge
    bus.in_valid = 1'b0;
  endtask

  // lat counts rising edges after the accepting edge until out_valid is seen;
  // an overflow result is already valid in the cycle right after accept.
  task automatic run_op(input int dvd, input int dvs, input int hold, input string tag);
    res_t e;
    int lat = 0;
    logic [31:0] sq, sr, so;
    e = model(dvd, dvs);
    start_op(dvd, dvs);
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_latency"}, lat, e.o ? 0 : 8);
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_quotient"}, bus.quotient, e.q);
    check({tag, "_remainder"}, bus.remainder, e.r);
    check({tag, "_ovf"}, bus.ovf, e.o);
`ifdef CDD_DIV0_FLAG_EN
    check({tag, "_div0"}, bus.div0, e.z);
`endif
    sq = bus.quotient; sr = bus.remainder; so = bus.ovf;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, bus.out_valid, 1);
      check({tag, "_hold_in_ready"}, bus.in_ready, 0);
      check({tag, "_hold_quotient"}, bus.quotient, sq);
      check({tag, "_hold_remainder"}, bus.remainder, sr);
      check({tag, "_hold_ovf"}, bus.ovf, so);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_release_valid"}, bus.out_valid, 0);
    check({tag, "_release_in_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, o0, g, dvs, dvd;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_quotient", bus.quotient, 0);
    check("reset_remainder", bus.remainder, 0);
    check("reset_ovf", bus.ovf, 0);
`ifdef CDD_DIV0_FLAG_EN
    check("reset_div0", bus.div0, 0);
`endif

    run_op(200, 7, 0, "d200_7");
    check("d200_7_q_const", out_log[$].q, 28);
    run_op(3825, 15, 0, "d3825_15");
    run_op(3840, 15, 0, "ovf3840_15");
    run_op(100, 0, 0, "div0_100");
    run_op(255, 1, 0, "d255_1");
    run_op(1000, 9, 5, "bp1000_9");

    // Abort after three BUSY steps.
    start_op(200, 7);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_quotient", bus.quotient, 0);
    check("abort_remainder", bus.remainder, 0);
    check("abort_ovf", bus.ovf, 0);
    run_op(99, 9, 0, "d99_9");
    check("d99_9_q_const", out_log[$].q, 11);

    // Back-to-back with in_valid held high and the consumer always ready.
    a0 = n_acc; o0 = n_out;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.dividend  = 12'd50;
    bus.divisor   = 4'd5;
    g = 0;
    while (n_acc == a0 && g < 50) begin @(posedge clk); #1; g++; end
    bus.dividend = 12'd51;
    g = 0;
    while (n_acc == a0 + 1 && g < 50) begin @(posedge clk); #1; g++; end
    bus.in_valid = 1'b0;
    g = 0;
    while (n_out < o0 + 2 && g < 50) begin @(posedge clk); #1; g++; end
    repeat (12) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check("b2b_accepts", n_acc - a0, 2);
    check("b2b_results", n_out - o0, 2);
    if (out_log.size() >= 2) begin
      check("b2b_first_q", out_log[$-1].q, 10);
      check("b2b_first_r", out_log[$-1].r, 0);
      check("b2b_second_q", out_log[$].q, 10);
      check("b2b_second_r", out_log[$].r, 1);
    end else begin
      check("b2b_log_size", out_log.size(), 2);
    end

    // Randomized operands, biased toward the non-overflow range.
    for (int i = 0; i < 120; i++) begin
      dvs = int'($urandom_range(0, 15));
      if (dvs == 0 || $urandom_range(0, 3) == 0)
        dvd = int'($urandom_range(0, 4095));
      else
        dvd = int'($urandom_range(0, dvs * 256 - 1));
      run_op(dvd, dvs, int'($urandom_range(0, 2)), "rand");
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 0);
    check("sb_all_answered", n_out, n_acc - 1);  // one accept was aborted by reset
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
